serial_add_ctrl: RTL
====================

# serial_add_ctrl

Bit-serial add/subtract controller that time-multiplexes one 1-bit full-adder cell (sum = a^b^cin, cout = majority) across a WIDTH-bit operation. It latches the operands and steps the cell one bit per clock, LSB first, holding the carry in a flip-flop between steps. It produces the result and NZCV flags for the ALU flag logic. It sits beside the parallel ALU as the low-area arithmetic path, driven by a start/done handshake.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when not busy
- subtract  in  1  0: A+B, 1: A−B (A + ~B + 1); sampled with start
- operand_a  in  WIDTH  addend/minuend; sampled with start
- operand_b  in  WIDTH  addend/subtrahend; sampled with start
- busy  out  1  high while in SHIFT
- done  out  1  one-cycle pulse, result/flags valid
- result  out  WIDTH  last completed sum/difference
- negative  out  1  result[WIDTH−1]
- zero  out  1  result == 0
- carry  out  1  final carry out of bit WIDTH−1
- overflow  out  1  carry into MSB XOR carry out of MSB

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE.
- IDLE/DONE with start=1:
  - Load shift_a ← operand_a and shift_b ← subtract ? ~operand_b : operand_b.
  - Set carry_ff ← subtract and bit_cnt ← 0.
  - Go to SHIFT.
- IDLE/DONE with start=0: go to (or stay in) IDLE.
- SHIFT, each cycle:
  - Cell inputs: shift_a[0], shift_b[0], carry_ff.
  - Sum bit shifts into the MSB of shift_s; shift_a and shift_b shift right.
  - carry_ff ← cell cout.
  - When bit_cnt == WIDTH−2, capture cell cout into cin_msb.
  - bit_cnt increments. When bit_cnt == WIDTH−1, go to DONE.
- Transition to DONE commits all of the following on the same edge:
  - result ← final shift_s
  - carry ← final cout
  - overflow ← cin_msb ^ final cout
  - negative ← MSB of result; zero ← (result == 0)
- result and flags hold their value until the next commit. Intermediate values are never visible on the outputs.
- start while busy is ignored, with no queuing. The operand and subtract inputs are don't-care while busy.
- Subtraction carry follows the ARM convention: carry=1 means no borrow.
- Arithmetic is modulo 2^WIDTH.

## Timing
- Reset values: busy=0, done=0, result=0, negative=0, zero=0, carry=0, overflow=0; internal registers 0. The asynchronous assert takes effect immediately.
- Reset mid-operation aborts the operation. result and flags return to 0, not to their previous values.
- Start accepted on edge E0: busy=1 from E0 through edge E0+WIDTH.
- done=1 and new outputs are valid for exactly the one cycle after edge E0+WIDTH.
- Latency is WIDTH+1 cycles, start edge to done.
- Back-to-back: start=1 during the done cycle is accepted. busy rises on the next edge with no IDLE bubble, so throughput is one operation per WIDTH+1 cycles.
- busy and done are never both 1.

## Configuration
- SERIAL_ADD_FLAGS_EN defined:
  - negative, zero, carry and overflow behave as above.
  - cin_msb and the flag registers are present.
- Not defined:
  - The four flag outputs are tied to 0.
  - cin_msb and the flag registers are removed.
  - result, busy, done and latency are unchanged.

## Test plan
- Add, WIDTH=8, A=0x3C, B=0x05, subtract=0 → done exactly 9 cycles after the start edge; result=0x41, N=0, Z=0, C=0, V=0.
- Signed overflow, WIDTH=8, A=0x7F, B=0x01, subtract=0 → result=0x80, N=1, V=1, C=0.
- Subtract to zero, WIDTH=8, A=0x55, B=0x55, subtract=1 → result=0x00, Z=1, C=1, V=0.
- Borrow and unsigned wrap, WIDTH=8:
  - A=0x00, B=0x01, subtract=1 → result=0xFF, N=1, C=0.
  - Then, with start held during the done cycle, A=0xFF, B=0x01, subtract=0 → busy rises on the next edge; result=0x00, C=1, Z=1.
- start pulsed mid-SHIFT with different operands → ignored; original result delivered on schedule; no extra done.
- reset_n low at cycle 4 of an operation → busy, done, result and flags are 0 immediately. After release, a new start completes normally in WIDTH+1 cycles.
- With SERIAL_ADD_FLAGS_EN undefined: rerun the 0x7F+0x01 case → result=0x80; all flag outputs 0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract controller.
// One 1-bit full-adder cell is stepped across a WIDTH-bit operation, LSB
// first, with the carry held in a flip-flop between steps. Latency is
// WIDTH+1 cycles from the start edge to the done pulse.
//
// Handshake: start is accepted on any rising edge where busy is 0 (IDLE or
// DONE state). busy is high for exactly WIDTH cycles while bits are processed.
// done pulses for one cycle with result/flags valid. start while busy is
// dropped. Asserting start during the done cycle chains the next operation
// with no idle bubble.
//
// Optional feature macro: SERIAL_ADD_FLAGS_EN. When defined, the NZCV flag
// registers exist. Otherwise the four flag outputs are tied to 0.
// dbg_state exposes the FSM state encoding (0 IDLE, 1 SHIFT, 2 DONE).

module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] shift_a, shift_b, shift_s;
    logic [CW-1:0]    bit_cnt;
    logic             carry_ff;
    logic             cell_sum, cell_cout;
    logic [WIDTH-1:0] shift_s_next;
    logic             last_bit, accept;

    // Full-adder cell and the next partial-sum value
    always_comb begin
        cell_sum     = shift_a[0] ^ shift_b[0] ^ carry_ff;
        cell_cout    = (shift_a[0] & shift_b[0]) | (shift_a[0] & carry_ff) |
                       (shift_b[0] & carry_ff);
        shift_s_next = {cell_sum, shift_s[WIDTH-1:1]};
        last_bit     = (bit_cnt == CW'(WIDTH - 1));
        accept       = (state_q != SHIFT) && start;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? SHIFT : IDLE;
            SHIFT:      state_d = last_bit ? DONE : SHIFT;
            default:    state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

    // Operand shift registers, carry flip-flop, bit counter and result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_a  <= '0;
            shift_b  <= '0;
            shift_s  <= '0;
            bit_cnt  <= '0;
            carry_ff <= 1'b0;
            result   <= '0;
        end else if (accept) begin
            shift_a  <= operand_a;
            shift_b  <= subtract ? ~operand_b : operand_b;
            carry_ff <= subtract;
            bit_cnt  <= '0;
        end else if (state_q == SHIFT) begin
            shift_a  <= {1'b0, shift_a[WIDTH-1:1]};
            shift_b  <= {1'b0, shift_b[WIDTH-1:1]};
            shift_s  <= shift_s_next;
            carry_ff <= cell_cout;
            bit_cnt  <= bit_cnt + CW'(1);
            if (last_bit) result <= shift_s_next;
        end
    end

`ifdef SERIAL_ADD_FLAGS_EN
    logic cin_msb;
    logic neg_q, zero_q, carry_q, ovf_q;

    // Carry into the MSB and NZCV flags, committed together with result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cin_msb <= 1'b0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == SHIFT) begin
            if (bit_cnt == CW'(WIDTH - 2)) cin_msb <= cell_cout;
            if (last_bit) begin
                neg_q   <= shift_s_next[WIDTH-1];
                zero_q  <= (shift_s_next == '0);
                carry_q <= cell_cout;
                ovf_q   <= cin_msb ^ cell_cout;
            end
        end
    end

    assign negative = neg_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
`else
    assign negative = 1'b0;
    assign zero     = 1'b0;
    assign carry    = 1'b0;
    assign overflow = 1'b0;
`endif

endmodule
